// File: rtl/fft_axi_mem_bridge.sv
// AXI slave front-end for the FFT sample/result memory: splits 64-bit AXI beats into
// pairs of 32-bit memory accesses and shares the memory port with the FFT engine.
module fft_axi_mem_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MEM_DEPTH      = 2048
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr_i,
  input  logic                      axi_awvalid_i,
  output logic                      axi_awready_o,
  input  logic [AXI_DATA_WIDTH-1:0] axi_wdata_i,
  input  logic                      axi_wvalid_i,
  output logic                      axi_wready_o,
  output logic [1:0]                axi_bresp_o,
  output logic                      axi_bvalid_o,
  input  logic                      axi_bready_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr_i,
  input  logic                      axi_arvalid_i,
  output logic                      axi_arready_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata_o,
  output logic [1:0]                axi_rresp_o,
  output logic                      axi_rvalid_o,
  input  logic                      axi_rready_i,
  input  logic                      fft_busy_i,
  input  logic [15:0]               eng_addr_i,
  input  logic [31:0]               eng_wdata_i,
  input  logic                      eng_write_i,
  output logic                      eng_gnt_o,
  output logic [15:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic                      mem_write_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int WORD_AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, WR_RESP, RD_LO, RD_HI, RD_CAP, RD_RESP
  } state_t;

  state_t                    state_reg;
  logic [15:0]               word_addr_reg;
  logic [AXI_DATA_WIDTH-1:0] wdata_reg;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]                bresp_reg;
  logic [1:0]                rresp_reg;

  logic        wr_accept;
  logic        rd_accept;
  logic        bridge_write;
  logic [15:0] bridge_addr;
  logic [31:0] bridge_wdata;

  // Legal means 8-byte aligned and inside the word array.
  function automatic logic addr_legal(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a[2:0] == 3'b000) && (a[AXI_ADDR_WIDTH-1:WORD_AW+2] == '0);
  endfunction

  function automatic logic [15:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] a);
    return {{(16-WORD_AW){1'b0}}, a[2 +: WORD_AW]};
  endfunction

  assign wr_accept = reset_n_i && (state_reg == IDLE) && !fft_busy_i
                     && axi_awvalid_i && axi_wvalid_i;
  assign rd_accept = reset_n_i && (state_reg == IDLE) && !fft_busy_i
                     && !(axi_awvalid_i && axi_wvalid_i) && axi_arvalid_i;

  assign axi_awready_o = wr_accept;
  assign axi_wready_o  = wr_accept;
  assign axi_arready_o = rd_accept;
  assign axi_bvalid_o  = (state_reg == WR_RESP);
  assign axi_bresp_o   = bresp_reg;
  assign axi_rvalid_o  = (state_reg == RD_RESP);
  assign axi_rresp_o   = rresp_reg;
  assign axi_rdata_o   = rdata_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      word_addr_reg <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      bresp_reg     <= RESP_OKAY;
      rresp_reg     <= RESP_OKAY;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wr_accept) begin
            word_addr_reg <= word_index(axi_awaddr_i);
            wdata_reg     <= axi_wdata_i;
            if (addr_legal(axi_awaddr_i)) begin
              bresp_reg <= RESP_OKAY;
              state_reg <= WR_LO;
            end else begin
              bresp_reg <= RESP_SLVERR;
              state_reg <= WR_RESP;
            end
          end else if (rd_accept) begin
            word_addr_reg <= word_index(axi_araddr_i);
            rdata_reg     <= '0;
            if (addr_legal(axi_araddr_i)) begin
              rresp_reg <= RESP_OKAY;
              state_reg <= RD_LO;
            end else begin
              rresp_reg <= RESP_SLVERR;
              state_reg <= RD_RESP;
            end
          end
        end
        WR_LO:   state_reg <= WR_HI;
        WR_HI:   state_reg <= WR_RESP;
        WR_RESP: if (axi_bready_i) state_reg <= IDLE;
        RD_LO:   state_reg <= RD_HI;
        // Memory data lags the address by one cycle, so each half lands a state later.
        RD_HI: begin
          rdata_reg[31:0] <= mem_rdata_i;
          state_reg       <= RD_CAP;
        end
        RD_CAP: begin
          rdata_reg[63:32] <= mem_rdata_i;
          state_reg        <= RD_RESP;
        end
        RD_RESP: if (axi_rready_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    eng_gnt_o    = (state_reg == IDLE) || (state_reg == WR_RESP) || (state_reg == RD_RESP);
    bridge_write = (state_reg == WR_LO) || (state_reg == WR_HI);
    bridge_addr  = ((state_reg == WR_HI) || (state_reg == RD_HI)) ? word_addr_reg + 16'd1
                                                                   : word_addr_reg;
    bridge_wdata = (state_reg == WR_HI) ? wdata_reg[63:32] : wdata_reg[31:0];
    if (eng_gnt_o) begin
      mem_addr_o  = eng_addr_i;
      mem_wdata_o = eng_wdata_i;
      mem_write_o = reset_n_i && eng_write_i;
    end else begin
      mem_addr_o  = bridge_addr;
      mem_wdata_o = bridge_wdata;
      mem_write_o = reset_n_i && bridge_write;
    end
  end

endmodule

// File: tb/tb_fft_axi_mem_bridge.sv
// Directed bench for fft_axi_mem_bridge with a registered-read 32-bit memory model.
module tb_fft_axi_mem_bridge;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] axi_awaddr_i = '0;
  logic        axi_awvalid_i = 1'b0;
  logic        axi_awready_o;
  logic [63:0] axi_wdata_i = '0;
  logic        axi_wvalid_i = 1'b0;
  logic        axi_wready_o;
  logic [1:0]  axi_bresp_o;
  logic        axi_bvalid_o;
  logic        axi_bready_i = 1'b0;
  logic [31:0] axi_araddr_i = '0;
  logic        axi_arvalid_i = 1'b0;
  logic        axi_arready_o;
  logic [63:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic        axi_rvalid_o;
  logic        axi_rready_i = 1'b0;
  logic        fft_busy_i = 1'b0;
  logic [15:0] eng_addr_i = '0;
  logic [31:0] eng_wdata_i = '0;
  logic        eng_write_i = 1'b0;
  logic        eng_gnt_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic [31:0] mem_rdata_i = '0;

  logic [31:0] mem_model [0:65535];
  int wr_count = 0;
  int errors = 0;
  int checks = 0;

  fft_axi_mem_bridge dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .axi_awaddr_i(axi_awaddr_i), .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
    .axi_araddr_i(axi_araddr_i), .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o), .axi_rvalid_o(axi_rvalid_o),
    .axi_rready_i(axi_rready_i),
    .fft_busy_i(fft_busy_i), .eng_addr_i(eng_addr_i), .eng_wdata_i(eng_wdata_i),
    .eng_write_i(eng_write_i), .eng_gnt_o(eng_gnt_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_write_o(mem_write_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory with one-cycle registered read, as on the real port
  always @(posedge clk_i) begin
    mem_rdata_i <= mem_model[mem_addr_o];
    if (mem_write_o) begin
      mem_model[mem_addr_o] <= mem_wdata_o;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = '0;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           output int lat, output logic [1:0] resp);
    int n;
    axi_awaddr_i = addr; axi_wdata_i = data; axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    #1;
    n = 0;
    while (!(axi_awready_o && axi_wready_o) && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      lat = -1;
    end else begin
      tick();
      axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
      lat = 1;
      while (!axi_bvalid_o && lat < 20) begin tick(); lat++; end
      if (!axi_bvalid_o) lat = -1;
    end
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    resp = axi_bresp_o;
    $display("write addr=%h data=%h lat=%0d bresp=%0d", addr, data, lat, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output int lat,
                          output logic [63:0] data, output logic [1:0] resp);
    int n;
    axi_araddr_i = addr; axi_arvalid_i = 1'b1;
    #1;
    n = 0;
    while (!axi_arready_o && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      lat = -1;
    end else begin
      tick();
      axi_arvalid_i = 1'b0;
      lat = 1;
      while (!axi_rvalid_o && lat < 20) begin tick(); lat++; end
      if (!axi_rvalid_o) lat = -1;
    end
    axi_arvalid_i = 1'b0;
    data = axi_rdata_o;
    resp = axi_rresp_o;
    $display("read  addr=%h data=%h lat=%0d rresp=%0d", addr, data, lat, resp);
  endtask

  task automatic finish_b;
    axi_bready_i = 1'b1; tick(); axi_bready_i = 1'b0;
  endtask

  task automatic finish_r;
    axi_rready_i = 1'b1; tick(); axi_rready_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    tick(); tick();
    checks++;
    if ({axi_awready_o, axi_wready_o, axi_arready_o, axi_bvalid_o, axi_rvalid_o, mem_write_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {axi_awready_o, axi_wready_o, axi_arready_o, axi_bvalid_o, axi_rvalid_o, mem_write_o});
    end
    checks++;
    if (axi_rdata_o !== 64'h0 || axi_bresp_o !== 2'b00 || axi_rresp_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: rdata=%h bresp=%0d rresp=%0d expected 0", axi_rdata_o, axi_bresp_o, axi_rresp_o);
    end
    reset_n_i = 1'b1;
    tick();
    checks++;
    if (eng_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt: got %b expected 1", eng_gnt_o); end
    $display("reset done");
  endtask

  task automatic test_write;
    axi_awaddr_i = 32'h40; axi_wdata_i = 64'hDEADBEEF_01234567;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    #1;
    checks++;
    if (axi_awready_o !== 1'b1 || axi_wready_o !== 1'b1) begin
      errors++; $display("FAIL write_ready: aw=%b w=%b expected 1 1", axi_awready_o, axi_wready_o);
    end
    tick();
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    checks++;
    if (mem_write_o !== 1'b1 || mem_addr_o !== 16'h10 || mem_wdata_o !== 32'h01234567 || eng_gnt_o !== 1'b0) begin
      errors++; $display("FAIL write_lo: we=%b addr=%h data=%h gnt=%b expected 1 0010 01234567 0", mem_write_o, mem_addr_o, mem_wdata_o, eng_gnt_o);
    end
    tick();
    checks++;
    if (mem_write_o !== 1'b1 || mem_addr_o !== 16'h11 || mem_wdata_o !== 32'hDEADBEEF || axi_bvalid_o !== 1'b0) begin
      errors++; $display("FAIL write_hi: we=%b addr=%h data=%h bvalid=%b expected 1 0011 deadbeef 0", mem_write_o, mem_addr_o, mem_wdata_o, axi_bvalid_o);
    end
    tick();
    checks++;
    if (axi_bvalid_o !== 1'b1 || axi_bresp_o !== 2'b00) begin
      errors++; $display("FAIL write_bresp: bvalid=%b bresp=%0d expected 1 0 at cycle 3", axi_bvalid_o, axi_bresp_o);
    end
    checks++;
    if (mem_model[16'h10] !== 32'h01234567 || mem_model[16'h11] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_mem: got %h %h expected 01234567 deadbeef", mem_model[16'h10], mem_model[16'h11]);
    end
    finish_b();
    checks++;
    if (axi_bvalid_o !== 1'b0) begin errors++; $display("FAIL write_bdone: bvalid=%b expected 0", axi_bvalid_o); end
    $display("write addr=00000040 data=deadbeef01234567 done");
  endtask

  task automatic test_read;
    int lat; logic [63:0] data; logic [1:0] resp;
    axi_read(32'h40, lat, data, resp);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", lat); end
    checks++;
    if (data !== 64'hDEADBEEF_01234567 || resp !== 2'b00) begin
      errors++; $display("FAIL read_data: got %h resp %0d expected deadbeef01234567 resp 0", data, resp);
    end
    finish_r();
    checks++;
    if (axi_rvalid_o !== 1'b0) begin errors++; $display("FAIL read_rdone: rvalid=%b expected 0", axi_rvalid_o); end
  endtask

  task automatic test_illegal;
    int lat; logic [63:0] data; logic [1:0] resp; int cnt0;
    cnt0 = wr_count;
    axi_write(32'h2000, 64'hAAAA_BBBB_CCCC_DDDD, lat, resp);
    checks++;
    if (lat < 0 || resp !== 2'b10) begin errors++; $display("FAIL illegal_range: lat=%0d resp=%0d expected resp 2", lat, resp); end
    finish_b();
    axi_write(32'h44, 64'h1111_2222_3333_4444, lat, resp);
    checks++;
    if (lat < 0 || resp !== 2'b10) begin errors++; $display("FAIL illegal_align: lat=%0d resp=%0d expected resp 2", lat, resp); end
    finish_b();
    checks++;
    if (wr_count !== cnt0) begin errors++; $display("FAIL illegal_nowrite: writes=%0d expected %0d", wr_count, cnt0); end
    axi_read(32'h2000, lat, data, resp);
    checks++;
    if (lat < 0 || resp !== 2'b10 || data !== 64'h0) begin
      errors++; $display("FAIL illegal_read: lat=%0d data=%h resp=%0d expected 0 resp 2", lat, data, resp);
    end
    finish_r();
  endtask

  task automatic test_back_to_back;
    int lat; logic bad; logic [63:0] held;
    axi_awaddr_i = 32'h80; axi_wdata_i = 64'hCAFEF00D_12345678; axi_araddr_i = 32'h80;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    #1;
    checks++;
    if (axi_awready_o !== 1'b1 || axi_arready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_priority: awready=%b arready=%b expected 1 0", axi_awready_o, axi_arready_o);
    end
    tick();
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    tick(); tick();
    checks++;
    if (axi_bvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_bvalid: got %b expected 1", axi_bvalid_o); end
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (axi_bvalid_o !== 1'b1 || axi_bresp_o !== 2'b00 || axi_arready_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL b2b_bhold: bvalid=%b bresp=%0d arready=%b expected 1 0 0", axi_bvalid_o, axi_bresp_o, axi_arready_o); end
    finish_b();
    checks++;
    if (axi_arready_o !== 1'b1) begin errors++; $display("FAIL b2b_read_accept: arready=%b expected 1", axi_arready_o); end
    tick();
    axi_arvalid_i = 1'b0;
    lat = 1;
    while (!axi_rvalid_o && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat !== 4 || axi_rdata_o !== 64'hCAFEF00D_12345678 || axi_rresp_o !== 2'b00) begin
      errors++; $display("FAIL b2b_read: lat=%0d data=%h resp=%0d expected 4 cafef00d12345678 0", lat, axi_rdata_o, axi_rresp_o);
    end
    held = 64'hCAFEF00D_12345678;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== held) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL b2b_rhold: rvalid=%b data=%h expected 1 %h", axi_rvalid_o, axi_rdata_o, held); end
    finish_r();
    checks++;
    if (axi_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_rdone: rvalid=%b expected 0", axi_rvalid_o); end
    $display("back-to-back write/read addr=00000080 done");
  endtask

  task automatic test_busy;
    logic bad_rdy, bad_mux;
    fft_busy_i = 1'b1; eng_write_i = 1'b1; eng_addr_i = 16'h7; eng_wdata_i = 32'h55;
    axi_awaddr_i = 32'h40; axi_araddr_i = 32'h40;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    #1;
    bad_rdy = 1'b0; bad_mux = 1'b0;
    repeat (3) begin
      if (axi_awready_o || axi_wready_o || axi_arready_o) bad_rdy = 1'b1;
      if (eng_gnt_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 16'h7 || mem_wdata_o !== 32'h55) bad_mux = 1'b1;
      tick();
    end
    checks++;
    if (bad_rdy !== 1'b0) begin errors++; $display("FAIL busy_ready: aw=%b ar=%b expected 0 0", axi_awready_o, axi_arready_o); end
    checks++;
    if (bad_mux !== 1'b0) begin errors++; $display("FAIL busy_mux: gnt=%b we=%b addr=%h data=%h expected 1 1 0007 00000055", eng_gnt_o, mem_write_o, mem_addr_o, mem_wdata_o); end
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0; axi_arvalid_i = 1'b0; eng_write_i = 1'b0;
    checks++;
    if (mem_model[7] !== 32'h55) begin errors++; $display("FAIL busy_engwrite: mem[7]=%h expected 00000055", mem_model[7]); end
    $display("engine write addr=0007 data=00000055 done");

    fft_busy_i = 1'b0; axi_arvalid_i = 1'b1;
    #1;
    tick();
    axi_arvalid_i = 1'b0;
    tick();
    fft_busy_i = 1'b1;
    checks++;
    if (eng_gnt_o !== 1'b0) begin errors++; $display("FAIL busy_rdhi_gnt: got %b expected 0", eng_gnt_o); end
    tick(); tick();
    checks++;
    if (axi_rvalid_o !== 1'b1 || eng_gnt_o !== 1'b1 || axi_rdata_o !== 64'hDEADBEEF_01234567) begin
      errors++; $display("FAIL busy_read: rvalid=%b gnt=%b data=%h expected 1 1 deadbeef01234567", axi_rvalid_o, eng_gnt_o, axi_rdata_o);
    end
    finish_r();
    axi_arvalid_i = 1'b1;
    #1;
    checks++;
    if (axi_arready_o !== 1'b0) begin errors++; $display("FAIL busy_block: arready=%b expected 0", axi_arready_o); end
    axi_arvalid_i = 1'b0; fft_busy_i = 1'b0;
    tick();
    $display("read under rising busy addr=00000040 done");
  endtask

  task automatic test_reset_mid;
    logic bad;
    axi_awaddr_i = 32'h100; axi_wdata_i = 64'h11111111_22222222;
    axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1;
    #1;
    tick();
    axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0;
    tick();
    checks++;
    if (mem_write_o !== 1'b1 || mem_addr_o !== 16'h41) begin
      errors++; $display("FAIL rstmid_whi: we=%b addr=%h expected 1 0041", mem_write_o, mem_addr_o);
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (mem_write_o !== 1'b0 || eng_gnt_o !== 1'b1 || axi_bvalid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: we=%b gnt=%b bvalid=%b expected 0 1 0", mem_write_o, eng_gnt_o, axi_bvalid_o);
    end
    tick(); tick();
    reset_n_i = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (axi_bvalid_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_nob: bvalid=%b expected 0", axi_bvalid_o); end
    checks++;
    if (mem_model[16'h41] !== 32'h0) begin errors++; $display("FAIL rstmid_hi_written: mem[41]=%h expected 00000000", mem_model[16'h41]); end
    $display("reset during write addr=00000100 done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
